div_nnbit_shift: RTL

//   Multi-cycle shift-subtract (restoring) divider, the inverse of the shift-add multiplier in calc/.

---
 rtl/div_nnbit_shift_pkg.sv | 4 +
 rtl/div_nnbit_shift_if.sv | 14 +
 rtl/div_nnbit_shift.sv | 88 ++++++++
 3 files changed

// File: rtl/div_nnbit_shift_pkg.sv
// div_nnbit_pkg: shared types for the shift-subtract divider
package div_nnbit_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
endpackage

// File: rtl/div_nnbit_shift_if.sv
// div_nnbit_shift_if: request/result bundle between the calc datapath and the divider
interface div_nnbit_shift_if #(parameter int DATA_WIDTH = 8);
    logic                  i_vld;
    logic                  i_signed;
    logic [DATA_WIDTH-1:0] i_num_x;
    logic [DATA_WIDTH-1:0] i_num_y;
    logic                  o_rdy;
    logic                  o_end;
    logic [DATA_WIDTH-1:0] o_quo;
    logic [DATA_WIDTH-1:0] o_rem;
    logic                  o_err;
    modport master (output i_vld, i_signed, i_num_x, i_num_y, input o_rdy, o_end, o_quo, o_rem, o_err);
    modport slave  (input i_vld, i_signed, i_num_x, i_num_y, output o_rdy, o_end, o_quo, o_rem, o_err);
endinterface

// File: rtl/div_nnbit_shift.sv
// div_nnbit_shift: multi-cycle restoring divider on magnitudes with sign fix-up, signed or unsigned
module div_nnbit_shift
    import div_nnbit_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic              i_clk,
    input logic              i_rst_n,
    div_nnbit_shift_if.slave bus
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);
    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          sx_q, sy_q, err_q;
    logic [N-1:0]  ay_q, quo_q, prem_q, oquo_q, orem_q;
    logic [N:0]    trial;
    logic [N-1:0]  quo_d, rem_d, ax, ay;
    logic          accept, last, dz, sx, sy;
    assign accept = (state_q == IDLE) && bus.i_vld;
    assign last   = cnt_q == CW'(N - 1);
    assign dz     = bus.i_num_y == '0;
    assign sx     = bus.i_signed & bus.i_num_x[N-1];
    assign sy     = bus.i_signed & bus.i_num_y[N-1];
    assign ax     = sx ? -bus.i_num_x : bus.i_num_x;
    assign ay     = sy ? -bus.i_num_y : bus.i_num_y;
    // state register and iteration counter; counter is zero whenever not iterating
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == CALC) ? cnt_q + 1'b1 : '0;
        end
    end
    // next state: divide-by-zero skips the iteration entirely
    always_comb begin
        state_d = (state_q == IDLE) ? (bus.i_vld ? (dz ? DONE : CALC) : IDLE) :
                  (state_q == CALC) ? (last ? DONE : CALC) : IDLE;
    end
    // one restoring step: shift in the next dividend bit, the borrow of the N+1 bit trial decides the quotient bit
    always_comb begin
        trial = {prem_q, quo_q[N-1]} - {1'b0, ay_q};
        quo_d = {quo_q[N-2:0], ~trial[N]};
        rem_d = trial[N] ? {prem_q[N-2:0], quo_q[N-1]} : trial[N-1:0];
    end
    // datapath: quo_q starts as |x| and is shifted out as quotient bits shift in; results are sign-fixed on the last step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sx_q   <= 1'b0;
            sy_q   <= 1'b0;
            ay_q   <= '0;
            quo_q  <= '0;
            prem_q <= '0;
            oquo_q <= '0;
            orem_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            sx_q   <= sx;
            sy_q   <= sy;
            ay_q   <= ay;
            quo_q  <= ax;
            prem_q <= '0;
            if (dz) begin
                oquo_q <= '1;
                orem_q <= bus.i_num_x;
                err_q  <= 1'b1;
            end
        end else if (state_q == CALC) begin
            quo_q  <= quo_d;
            prem_q <= rem_d;
            if (last) begin
                oquo_q <= (sx_q ^ sy_q) ? -quo_d : quo_d;
                orem_q <= sx_q ? -rem_d : rem_d;
                err_q  <= 1'b0;
            end
        end
    end
    // outputs: handshake decoded from state, results straight from their holding registers
    always_comb begin
        bus.o_rdy = state_q == IDLE;
        bus.o_end = state_q == DONE;
        bus.o_quo = oquo_q;
        bus.o_rem = orem_q;
        bus.o_err = err_q;
    end
endmodule
